mult_fu_ctrl: RTL and testbench

- Issue/retire controller wrapped around the pipelined multiplier.
- Accepts multiply ops from the mult reservation station and decodes the multiply function into operand sign modes.
- Drives the multiplier's start, operand and func inputs, and tracks each op's destination tag alongside the multiplier's fixed latency.
- Buffers completed results in a small FIFO until the CDB arbiter grants broadcast. Credit-based backpressure guarantees no result is ever dropped.

---
 rtl/mult_fu_ctrl_pkg.sv | 28 ++
 rtl/mult_fu_ctrl_result_fifo.sv | 69 ++++++
 rtl/mult_fu_ctrl.sv | 151 +++++++++++++++
 tb/tb_mult_fu_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_fu_ctrl_pkg.sv
// Shared definitions for the multiply functional-unit controller: datapath
// widths, multiply function codes and the result packet layout.
package mult_fu_ctrl_pkg;

  localparam int XLEN            = 32;
  localparam int DEF_MULT_STAGES = 4;
  localparam int DEF_TAG_W       = 6;
  localparam int ALU_FUNC_W      = 2;

  typedef enum logic [ALU_FUNC_W-1:0] {
    ALU_MUL    = 2'd0,
    ALU_MULH   = 2'd1,
    ALU_MULHSU = 2'd2,
    ALU_MULHU  = 2'd3
  } alu_func_e;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [XLEN-1:0]      value;
  } mult_result_packet_t;

  // Widen an operand to the multiplier's 2*XLEN input, sign- or zero-filled.
  function automatic logic [2*XLEN-1:0] extend_operand(input logic [XLEN-1:0] v,
                                                       input logic            is_signed);
    return is_signed ? {{XLEN{v[XLEN-1]}}, v} : {{XLEN{1'b0}}, v};
  endfunction

endpackage

// File: rtl/mult_fu_ctrl_result_fifo.sv
// Circular result buffer for completed multiplies; head is zero while empty.
// A pop and a push in the same cycle retire the head and append the new entry.
module mult_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 38,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W-1:0]  r_wr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_pop;
  logic              w_do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = o_empty ? '0 : r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= ptr_inc(r_wr);
      if (w_do_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the buffer is empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && o_full && !i_pop));
`endif

endmodule

// File: rtl/mult_fu_ctrl.sv
// Issue/retire controller around the pipelined multiplier: sign decode, tag
// pipe, credit-limited issue and a result FIFO feeding the CDB.
// Optional: define MULT_FU_BYPASS_EN to broadcast a completing result directly
// when the FIFO is empty.
module mult_fu_ctrl
  import mult_fu_ctrl_pkg::*;
#(
  parameter int MULT_STAGES  = DEF_MULT_STAGES,
  parameter int RESULT_DEPTH = 4,
  parameter int TAG_W        = DEF_TAG_W
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_issue_valid,
  output logic                  o_issue_ready,
  input  logic [XLEN-1:0]       i_issue_rs1,
  input  logic [XLEN-1:0]       i_issue_rs2,
  input  logic [ALU_FUNC_W-1:0] i_issue_func,
  input  logic [TAG_W-1:0]      i_issue_tag,
  output logic [2*XLEN-1:0]     o_mult_mcand,
  output logic [2*XLEN-1:0]     o_mult_mplier,
  output logic                  o_mult_signed1,
  output logic                  o_mult_signed2,
  output logic                  o_mult_start,
  output logic [ALU_FUNC_W-1:0] o_mult_func,
  input  logic [XLEN-1:0]       i_mult_product,
  input  logic                  i_mult_done,
  output logic                  o_cdb_req,
  output logic [TAG_W-1:0]      o_cdb_tag,
  output logic [XLEN-1:0]       o_cdb_value,
  input  logic                  i_cdb_grant
);

  // The issue cycle itself is the first multiplier stage, so only the
  // remaining stages need a registered tag slot.
  localparam int PIPE_N = MULT_STAGES - 1;
  localparam int CNT_W  = $clog2(RESULT_DEPTH + 1);
  localparam int OCC_W  = $clog2(RESULT_DEPTH + MULT_STAGES);
  localparam int PKT_W  = TAG_W + XLEN;

  logic [PIPE_N-1:0]     r_vld;
  logic [TAG_W-1:0]      r_tag  [PIPE_N];
  logic [ALU_FUNC_W-1:0] r_func [PIPE_N];

  logic                  w_fire;
  logic                  w_signed1;
  logic                  w_signed2;
  logic [OCC_W-1:0]      w_inflight;
  logic [OCC_W-1:0]      w_occupancy;
  logic                  w_tail_vld;
  logic [TAG_W-1:0]      w_tail_tag;
  logic [PKT_W-1:0]      w_result;
  logic                  w_push;
  logic [PKT_W-1:0]      w_fifo_head;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;

  always_comb begin
    w_signed1 = 1'b1;
    w_signed2 = 1'b1;
    case (alu_func_e'(i_issue_func))
      ALU_MUL:    begin w_signed1 = 1'b1; w_signed2 = 1'b1; end
      ALU_MULH:   begin w_signed1 = 1'b1; w_signed2 = 1'b1; end
      ALU_MULHSU: begin w_signed1 = 1'b1; w_signed2 = 1'b0; end
      ALU_MULHU:  begin w_signed1 = 1'b0; w_signed2 = 1'b0; end
      default:    begin w_signed1 = 1'b1; w_signed2 = 1'b1; end
    endcase
  end

  // Credits come from registered state only, so a grant frees its slot a cycle later.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < PIPE_N; k++) begin
      w_inflight = w_inflight + OCC_W'(r_vld[k]);
    end
  end

  assign w_occupancy    = w_inflight + OCC_W'(w_fifo_count);
  assign o_issue_ready  = (w_occupancy < OCC_W'(RESULT_DEPTH)) & ~i_flush;
  assign w_fire         = i_issue_valid & o_issue_ready;
  assign o_mult_start   = w_fire;
  assign o_mult_signed1 = w_signed1;
  assign o_mult_signed2 = w_signed2;
  assign o_mult_mcand   = extend_operand(i_issue_rs1, w_signed1);
  assign o_mult_mplier  = extend_operand(i_issue_rs2, w_signed2);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_vld <= '0;
      for (int k = 0; k < PIPE_N; k++) begin
        r_tag[k]  <= '0;
        r_func[k] <= ALU_MUL;
      end
    end else begin
      r_vld[0]  <= w_fire & ~i_flush;
      r_tag[0]  <= i_issue_tag;
      r_func[0] <= i_issue_func;
      for (int k = 1; k < PIPE_N; k++) begin
        r_vld[k]  <= r_vld[k-1] & ~i_flush;
        r_tag[k]  <= r_tag[k-1];
        r_func[k] <= r_func[k-1];
      end
    end
  end

  assign w_tail_vld  = r_vld[PIPE_N-1];
  assign w_tail_tag  = r_tag[PIPE_N-1];
  assign o_mult_func = r_func[PIPE_N-1];
  assign w_result    = {w_tail_tag, i_mult_product};

`ifdef MULT_FU_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_fifo_empty & w_tail_vld & ~i_flush;
  assign w_push      = w_tail_vld & ~i_flush & ~(w_bypass & i_cdb_grant);
  assign o_cdb_req   = ~w_fifo_empty | w_bypass;
  assign o_cdb_tag   = w_bypass ? w_tail_tag     : w_fifo_head[PKT_W-1:XLEN];
  assign o_cdb_value = w_bypass ? i_mult_product : w_fifo_head[XLEN-1:0];
`else
  assign w_push      = w_tail_vld & ~i_flush;
  assign o_cdb_req   = ~w_fifo_empty;
  assign o_cdb_tag   = w_fifo_head[PKT_W-1:XLEN];
  assign o_cdb_value = w_fifo_head[XLEN-1:0];
`endif

  mult_result_fifo #(
    .DEPTH  (RESULT_DEPTH),
    .DATA_W (PKT_W)
  ) u_result_fifo (
    .i_clk   (i_clock),
    .i_rst_n (i_reset),
    .i_clear (i_flush),
    .i_push  (w_push),
    .i_data  (w_result),
    .i_pop   (i_cdb_grant),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

`ifndef SYNTHESIS
  // Done pulses for squashed ops arrive with an invalid tail and are ignored.
  a_done_tracks_tail: assert property (@(posedge i_clock) disable iff (!i_reset)
    w_tail_vld |-> i_mult_done);
  a_no_credit_overrun: assert property (@(posedge i_clock) disable iff (!i_reset)
    !(w_push && w_fifo_full && !i_cdb_grant));
`endif

endmodule

// File: tb/tb_mult_fu_ctrl.sv
// Directed bench for mult_fu_ctrl with a behavioural pipelined multiplier
// that launches on o_mult_start and crops on o_mult_func at completion.
module tb_mult_fu_ctrl;
  import mult_fu_ctrl_pkg::*;

  localparam int S  = DEF_MULT_STAGES;
  localparam int MN = S - 1;

  logic                  i_clock = 1'b0;
  logic                  i_reset;
  logic                  i_flush;
  logic                  i_issue_valid;
  logic                  o_issue_ready;
  logic [XLEN-1:0]       i_issue_rs1;
  logic [XLEN-1:0]       i_issue_rs2;
  logic [ALU_FUNC_W-1:0] i_issue_func;
  logic [DEF_TAG_W-1:0]  i_issue_tag;
  logic [2*XLEN-1:0]     o_mult_mcand;
  logic [2*XLEN-1:0]     o_mult_mplier;
  logic                  o_mult_signed1;
  logic                  o_mult_signed2;
  logic                  o_mult_start;
  logic [ALU_FUNC_W-1:0] o_mult_func;
  logic [XLEN-1:0]       i_mult_product;
  logic                  i_mult_done;
  logic                  o_cdb_req;
  logic [DEF_TAG_W-1:0]  o_cdb_tag;
  logic [XLEN-1:0]       o_cdb_value;
  logic                  i_cdb_grant;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clock = ~i_clock;

  mult_fu_ctrl dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_flush        (i_flush),
    .i_issue_valid  (i_issue_valid),
    .o_issue_ready  (o_issue_ready),
    .i_issue_rs1    (i_issue_rs1),
    .i_issue_rs2    (i_issue_rs2),
    .i_issue_func   (i_issue_func),
    .i_issue_tag    (i_issue_tag),
    .o_mult_mcand   (o_mult_mcand),
    .o_mult_mplier  (o_mult_mplier),
    .o_mult_signed1 (o_mult_signed1),
    .o_mult_signed2 (o_mult_signed2),
    .o_mult_start   (o_mult_start),
    .o_mult_func    (o_mult_func),
    .i_mult_product (i_mult_product),
    .i_mult_done    (i_mult_done),
    .o_cdb_req      (o_cdb_req),
    .o_cdb_tag      (o_cdb_tag),
    .o_cdb_value    (o_cdb_value),
    .i_cdb_grant    (i_cdb_grant)
  );

  // Multiplier model: done MN edges after start; keeps running across flush and DUT reset.
  logic             mdl_rst_n;
  logic [MN-1:0]    mdl_vld;
  logic [63:0]      mdl_prod [MN];
  logic [63:0]      mdl_full;

  always @(posedge i_clock or negedge mdl_rst_n) begin
    if (!mdl_rst_n) begin
      mdl_vld <= '0;
      for (int k = 0; k < MN; k++) mdl_prod[k] <= '0;
    end else begin
      mdl_vld[0]  <= o_mult_start;
      mdl_prod[0] <= o_mult_mcand * o_mult_mplier;
      for (int k = 1; k < MN; k++) begin
        mdl_vld[k]  <= mdl_vld[k-1];
        mdl_prod[k] <= mdl_prod[k-1];
      end
    end
  end

  assign mdl_full       = mdl_prod[MN-1];
  assign i_mult_done    = mdl_vld[MN-1];
  assign i_mult_product = (o_mult_func == ALU_MUL) ? mdl_full[31:0] : mdl_full[63:32];

  task automatic next_cyc();
    @(posedge i_clock);
    #2;
  endtask

  task automatic test_reset();
    @(negedge i_clock);
    n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", o_issue_ready); end
    n_vec++; if (o_mult_start !== 1'b0) begin n_err++; $display("FAIL reset_start got %b exp 0", o_mult_start); end
    n_vec++; if (o_cdb_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", o_cdb_req); end
    n_vec++; if (o_cdb_tag !== '0) begin n_err++; $display("FAIL reset_tag got %h exp 0", o_cdb_tag); end
    n_vec++; if (o_cdb_value !== '0) begin n_err++; $display("FAIL reset_value got %h exp 0", o_cdb_value); end
    n_vec++; if (o_mult_func !== ALU_MUL) begin n_err++; $display("FAIL reset_func got %0d exp 0", o_mult_func); end
  endtask

  task automatic test_mulhu();
    int lat;
    bit seen;
    i_issue_valid = 1'b1; i_issue_func = ALU_MULHU;
    i_issue_rs1 = 32'hFFFF_FFFF; i_issue_rs2 = 32'h2; i_issue_tag = 6'd5;
    @(negedge i_clock);
    n_vec++; if (o_mult_start !== 1'b1) begin n_err++; $display("FAIL mulhu_start got %b exp 1", o_mult_start); end
    n_vec++; if ({o_mult_signed1, o_mult_signed2} !== 2'b00) begin n_err++; $display("FAIL mulhu_signs got %b exp 00", {o_mult_signed1, o_mult_signed2}); end
    n_vec++; if (o_mult_mcand !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL mulhu_mcand got %h exp 00000000ffffffff", o_mult_mcand); end
    n_vec++; if (o_mult_mplier !== 64'h2) begin n_err++; $display("FAIL mulhu_mplier got %h exp 2", o_mult_mplier); end
    next_cyc();
    i_issue_valid = 1'b0;
    seen = 0; lat = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge i_clock);
      if (o_cdb_req) begin seen = 1; lat = c; end
      else next_cyc();
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL mulhu_timeout got no cdb_req exp req"); end
    n_vec++; if (lat != S) begin n_err++; $display("FAIL mulhu_latency got %0d exp %0d", lat, S); end
    n_vec++; if (o_cdb_tag !== 6'd5) begin n_err++; $display("FAIL mulhu_tag got %0d exp 5", o_cdb_tag); end
    n_vec++; if (o_cdb_value !== 32'h1) begin n_err++; $display("FAIL mulhu_value got %h exp 1", o_cdb_value); end
    i_cdb_grant = 1'b1;
    next_cyc();
    i_cdb_grant = 1'b0;
    @(negedge i_clock);
    n_vec++; if (o_cdb_req !== 1'b0) begin n_err++; $display("FAIL mulhu_drain got %b exp 0", o_cdb_req); end
    next_cyc();
  endtask

  task automatic test_signed_modes();
    logic [ALU_FUNC_W-1:0] f_tab [3];
    logic [31:0]           v_tab [3];
    logic [1:0]            s_tab [3];
    bit                    seen;
    f_tab[0] = ALU_MULH;   v_tab[0] = 32'hFFFF_FFFF; s_tab[0] = 2'b11;
    f_tab[1] = ALU_MULHSU; v_tab[1] = 32'hFFFF_FFFF; s_tab[1] = 2'b10;
    f_tab[2] = ALU_MUL;    v_tab[2] = 32'hFFFF_FFFE; s_tab[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      i_issue_valid = 1'b1; i_issue_func = f_tab[i];
      i_issue_rs1 = 32'hFFFF_FFFF; i_issue_rs2 = 32'h2; i_issue_tag = 6'(20 + i);
      @(negedge i_clock);
      n_vec++; if ({o_mult_signed1, o_mult_signed2} !== s_tab[i]) begin n_err++; $display("FAIL sign_%0d got %b exp %b", i, {o_mult_signed1, o_mult_signed2}, s_tab[i]); end
      n_vec++; if (o_mult_mcand !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL mcand_%0d got %h exp ffffffffffffffff", i, o_mult_mcand); end
      next_cyc();
      i_issue_valid = 1'b0;
      seen = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
        @(negedge i_clock);
        if (o_cdb_req) seen = 1;
        else next_cyc();
      end
      n_vec++; if (!seen) begin n_err++; $display("FAIL signed_timeout_%0d got no req exp req", i); end
      n_vec++; if (o_cdb_tag !== 6'(20 + i)) begin n_err++; $display("FAIL signed_tag_%0d got %0d exp %0d", i, o_cdb_tag, 20 + i); end
      n_vec++; if (o_cdb_value !== v_tab[i]) begin n_err++; $display("FAIL signed_value_%0d got %h exp %h", i, o_cdb_value, v_tab[i]); end
      i_cdb_grant = 1'b1;
      next_cyc();
      i_cdb_grant = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    i_cdb_grant = 1'b0;
    for (int c = 0; c < 8; c++) begin
      i_issue_valid = (acc < 6); i_issue_func = ALU_MUL;
      i_issue_rs1 = 32'(acc + 1); i_issue_rs2 = 32'd3; i_issue_tag = 6'(acc);
      @(negedge i_clock);
      n_vec++; if (o_issue_ready !== (c < 4)) begin n_err++; $display("FAIL b2b_ready_c%0d got %b exp %b", c, o_issue_ready, (c < 4)); end
      if (o_issue_ready) acc++;
      next_cyc();
    end
    i_issue_valid = 1'b0;
    n_vec++; if (acc != 4) begin n_err++; $display("FAIL b2b_accepts got %0d exp 4", acc); end
    for (int k = 0; k < 4; k++) begin
      i_cdb_grant = 1'b1;
      @(negedge i_clock);
      n_vec++; if (o_cdb_req !== 1'b1) begin n_err++; $display("FAIL b2b_req_%0d got %b exp 1", k, o_cdb_req); end
      n_vec++; if (o_cdb_tag !== 6'(k)) begin n_err++; $display("FAIL b2b_tag_%0d got %0d exp %0d", k, o_cdb_tag, k); end
      n_vec++; if (o_cdb_value !== 32'(3 * (k + 1))) begin n_err++; $display("FAIL b2b_value_%0d got %0d exp %0d", k, o_cdb_value, 3 * (k + 1)); end
      n_vec++; if (o_issue_ready !== (k != 0)) begin n_err++; $display("FAIL b2b_reopen_%0d got %b exp %b", k, o_issue_ready, (k != 0)); end
      next_cyc();
    end
    i_cdb_grant = 1'b0;
    @(negedge i_clock);
    n_vec++; if (o_cdb_req !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %b exp 0", o_cdb_req); end
    next_cyc();
  endtask

  task automatic test_stream();
    int issued = 0;
    int rx = 0;
    int rx_cyc [16];
    int exp_cyc;
    i_cdb_grant = 1'b1;
    for (int c = 0; c < 80 && rx < 16; c++) begin
      i_issue_valid = (issued < 16); i_issue_func = ALU_MUL;
      i_issue_rs1 = 32'(issued + 1); i_issue_rs2 = 32'(issued + 2); i_issue_tag = 6'(10 + issued);
      @(negedge i_clock);
      if (o_cdb_req) begin
        n_vec++; if (o_cdb_tag !== 6'(10 + rx)) begin n_err++; $display("FAIL stream_tag_%0d got %0d exp %0d", rx, o_cdb_tag, 10 + rx); end
        n_vec++; if (o_cdb_value !== 32'((rx + 1) * (rx + 2))) begin n_err++; $display("FAIL stream_value_%0d got %0d exp %0d", rx, o_cdb_value, (rx + 1) * (rx + 2)); end
        rx_cyc[rx] = c;
        rx++;
      end
      if (i_issue_valid && o_issue_ready) issued++;
      next_cyc();
    end
    i_issue_valid = 1'b0;
    i_cdb_grant = 1'b0;
    n_vec++; if (rx != 16) begin n_err++; $display("FAIL stream_count got %0d exp 16", rx); end
    // Without bypass four ops fill the credit window, so every fifth slot bubbles.
    for (int k = 0; k < rx; k++) begin
`ifdef MULT_FU_BYPASS_EN
      exp_cyc = k + S - 1;
`else
      exp_cyc = k + k / 4 + S;
`endif
      n_vec++; if (rx_cyc[k] != exp_cyc) begin n_err++; $display("FAIL stream_cycle_%0d got %0d exp %0d", k, rx_cyc[k], exp_cyc); end
    end
  endtask

  task automatic test_flush();
    int req_seen = 0;
    bit seen;
    int lat;
    i_cdb_grant = 1'b0;
    i_issue_valid = 1'b1; i_issue_func = ALU_MUL;
    i_issue_rs1 = 32'd2; i_issue_rs2 = 32'd3; i_issue_tag = 6'd6;
    next_cyc();
    i_issue_valid = 1'b0;
    repeat (S) next_cyc();
    @(negedge i_clock);
    n_vec++; if (o_cdb_tag !== 6'd6) begin n_err++; $display("FAIL flush_buffered got %0d exp 6", o_cdb_tag); end
    next_cyc();
    i_issue_valid = 1'b1; i_issue_tag = 6'd7;
    next_cyc();
    i_issue_tag = 6'd8;
    next_cyc();
    i_issue_valid = 1'b0;
    next_cyc();
    i_flush = 1'b1; i_issue_valid = 1'b1; i_issue_tag = 6'd30;
    @(negedge i_clock);
    n_vec++; if (o_issue_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b exp 0", o_issue_ready); end
    n_vec++; if (o_mult_start !== 1'b0) begin n_err++; $display("FAIL flush_start got %b exp 0", o_mult_start); end
    next_cyc();
    i_flush = 1'b0; i_issue_valid = 1'b0;
    @(negedge i_clock);
    n_vec++; if (o_cdb_req !== 1'b0) begin n_err++; $display("FAIL flush_empty got %b exp 0", o_cdb_req); end
    n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL flush_credits got %b exp 1", o_issue_ready); end
    for (int c = 0; c < 8; c++) begin
      next_cyc();
      @(negedge i_clock);
      if (o_cdb_req) req_seen++;
    end
    n_vec++; if (req_seen != 0) begin n_err++; $display("FAIL flush_stale got %0d reqs exp 0", req_seen); end
    next_cyc();
    i_issue_valid = 1'b1; i_issue_func = ALU_MULHU;
    i_issue_rs1 = 32'hFFFF_FFFF; i_issue_rs2 = 32'hFFFF_FFFF; i_issue_tag = 6'd9;
    next_cyc();
    i_issue_valid = 1'b0;
    seen = 0; lat = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge i_clock);
      if (o_cdb_req) begin seen = 1; lat = c; end
      else next_cyc();
    end
    n_vec++; if (lat != S) begin n_err++; $display("FAIL flush_post_latency got %0d exp %0d", lat, S); end
    n_vec++; if (o_cdb_tag !== 6'd9) begin n_err++; $display("FAIL flush_post_tag got %0d exp 9", o_cdb_tag); end
    n_vec++; if (o_cdb_value !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL flush_post_value got %h exp fffffffe", o_cdb_value); end
    i_cdb_grant = 1'b1;
    next_cyc();
    i_cdb_grant = 1'b0;
  endtask

  task automatic test_reset_mid();
    int req_seen = 0;
    i_cdb_grant = 1'b0;
    i_issue_valid = 1'b1; i_issue_func = ALU_MULHU;
    i_issue_rs1 = 32'h1234; i_issue_rs2 = 32'h5678; i_issue_tag = 6'd4;
    next_cyc();
    i_issue_valid = 1'b0;
    repeat (S) next_cyc();
    for (int i = 1; i <= 3; i++) begin
      i_issue_valid = 1'b1; i_issue_tag = 6'(i);
      next_cyc();
    end
    i_issue_valid = 1'b0;
    @(negedge i_clock);
    n_vec++; if (o_cdb_req !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_req got %b exp 1", o_cdb_req); end
    n_vec++; if (o_mult_func !== ALU_MULHU) begin n_err++; $display("FAIL rstmid_pre_func got %0d exp 3", o_mult_func); end
    n_vec++; if (o_issue_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_pre_ready got %b exp 0", o_issue_ready); end
    #1 i_reset = 1'b0;
    #1;
    n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b exp 1", o_issue_ready); end
    n_vec++; if (o_cdb_req !== 1'b0) begin n_err++; $display("FAIL rstmid_req got %b exp 0", o_cdb_req); end
    n_vec++; if (o_cdb_tag !== '0) begin n_err++; $display("FAIL rstmid_tag got %0d exp 0", o_cdb_tag); end
    n_vec++; if (o_cdb_value !== '0) begin n_err++; $display("FAIL rstmid_value got %h exp 0", o_cdb_value); end
    n_vec++; if (o_mult_func !== ALU_MUL) begin n_err++; $display("FAIL rstmid_func got %0d exp 0", o_mult_func); end
    n_vec++; if (o_mult_start !== 1'b0) begin n_err++; $display("FAIL rstmid_start got %b exp 0", o_mult_start); end
    next_cyc();
    next_cyc();
    i_reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clock);
      if (o_cdb_req) req_seen++;
      next_cyc();
    end
    n_vec++; if (req_seen != 0) begin n_err++; $display("FAIL rstmid_stale got %0d reqs exp 0", req_seen); end
    @(negedge i_clock);
    n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_post_ready got %b exp 1", o_issue_ready); end
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0; mdl_rst_n = 1'b0;
    i_flush = 1'b0; i_issue_valid = 1'b0; i_issue_rs1 = '0; i_issue_rs2 = '0;
    i_issue_func = ALU_MUL; i_issue_tag = '0; i_cdb_grant = 1'b0;
    next_cyc();
    test_reset();
    next_cyc();
    i_reset = 1'b1; mdl_rst_n = 1'b1;
    next_cyc();
    test_mulhu();
    test_signed_modes();
    test_back_to_back();
    test_stream();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
